// File: rtl/fxp_pkg.sv
// Shared Q8.8 fixed-point definitions for the divider and multiplier datapaths.
package fxp_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned FRAC   = 8;
    localparam int unsigned N_ITER = WIDTH + FRAC;     // one quotient bit per iteration
    localparam int unsigned CNT_W  = $clog2(N_ITER);
    localparam int unsigned MAG_W  = N_ITER + 1;       // quotient magnitude plus rounding carry

    localparam logic [WIDTH-1:0] Q_MAX = 16'h7FFF;
    localparam logic [WIDTH-1:0] Q_MIN = 16'h8000;
    localparam logic [WIDTH-1:0] Q_ONE = 16'h0100;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFinal
    } div_state_e;

    // Unsigned magnitude of a two's-complement value; 0x8000 maps to 32768.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

endpackage

// File: rtl/fxp_sat.sv
// Magnitude + sign to saturated signed Q8.8, with overflow flag.
module fxp_sat
    import fxp_pkg::*;
#(
    parameter int unsigned MagW = MAG_W
) (
    input  logic [MagW-1:0]  mag_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] q_o,
    output logic             ovf_o
);

    localparam logic [MagW-1:0] PosLim = MagW'(Q_MAX);
    localparam logic [MagW-1:0] NegLim = MagW'(Q_MIN);   // 32768 as a magnitude

    // Clamp the magnitude to the range reachable for its sign, then apply the sign
    always_comb begin
        q_o   = '0;
        ovf_o = 1'b0;
        if (neg_i) begin
            if (mag_i > NegLim) begin
                q_o   = Q_MIN;
                ovf_o = 1'b1;
            end else begin
                // Zero magnitude negates to zero, never 0x8000
                q_o = ~mag_i[WIDTH-1:0] + WIDTH'(1);
            end
        end else begin
            if (mag_i > PosLim) begin
                q_o   = Q_MAX;
                ovf_o = 1'b1;
            end else begin
                q_o = mag_i[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/fxp_div.sv
// Iterative signed Q8.8 divider: radix-2 restoring division on magnitudes,
// one quotient bit per cycle, then sign, optional rounding and saturation.
// Build option: define FXP_DIV_ROUND_NEAREST_EN for round-half-away-from-zero;
// otherwise the magnitude is truncated toward zero.
module fxp_div
    import fxp_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] num_i,
    input  logic [WIDTH-1:0] den_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quo_o,
    output logic             ovf_o,
    output logic             div_by_zero_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_ITER - 1);

    div_state_e        state_q;
    logic [CNT_W-1:0]  count_q;
    logic              sign_q;
    logic              dz_q;          // captured den==0 for the operation in flight
    logic [N_ITER-1:0] dvd_q;         // dividend bits leave at the MSB, quotient bits enter at the LSB
    logic [WIDTH-1:0]  rem_q;         // always < V <= 32768
    logic [WIDTH:0]    v_q;
    logic [WIDTH-1:0]  quo_q;
    logic              ovf_q;
    logic              dz_flag_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH-1:0]  num_mag;
    logic [WIDTH-1:0]  den_mag;
    logic [WIDTH:0]    rem_sh;
    logic [WIDTH:0]    trial;
    logic              trial_borrow;
    logic [WIDTH-1:0]  rem_nxt;
    logic              unused_trial_msb;
    logic [MAG_W-1:0]  q_mag;
    logic [WIDTH-1:0]  sat_q;
    logic              sat_ovf;

    // Operand magnitudes and one restoring trial-subtract step
    always_comb begin
        num_mag                = abs_mag(num_i);
        den_mag                = abs_mag(den_i);
        rem_sh                 = {rem_q, dvd_q[N_ITER-1]};
        {trial_borrow, trial}  = {1'b0, rem_sh} - {1'b0, v_q};
        // A kept difference is below V, so its top bit is always zero
        rem_nxt                = trial_borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        unused_trial_msb       = trial[WIDTH];
    end

`ifdef FXP_DIV_ROUND_NEAREST_EN
    logic round_up;

    // Round half away from zero: bump the magnitude when 2*remainder >= V
    always_comb begin
        round_up = ({rem_q, 1'b0} >= v_q);
        q_mag    = {1'b0, dvd_q} + MAG_W'(round_up);
    end
`else
    // Truncate toward zero: the quotient magnitude is used as-is
    always_comb begin
        q_mag = {1'b0, dvd_q};
    end
`endif

    fxp_sat #(
        .MagW (MAG_W)
    ) u_sat (
        .mag_i (q_mag),
        .neg_i (sign_q),
        .q_o   (sat_q),
        .ovf_o (sat_ovf)
    );

    // Control FSM, iteration datapath and registered result outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            count_q   <= '0;
            sign_q    <= 1'b0;
            dz_q      <= 1'b0;
            dvd_q     <= '0;
            rem_q     <= '0;
            v_q       <= '0;
            quo_q     <= '0;
            ovf_q     <= 1'b0;
            dz_flag_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        sign_q  <= num_i[WIDTH-1] ^ den_i[WIDTH-1];
                        dz_q    <= (den_i == '0);
                        dvd_q   <= {num_mag, {FRAC{1'b0}}};
                        rem_q   <= '0;
                        v_q     <= {1'b0, den_mag};
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (den_i == '0) ? StFinal : StCalc;
                    end
                end
                StCalc: begin
                    rem_q   <= rem_nxt;
                    dvd_q   <= {dvd_q[N_ITER-2:0], ~trial_borrow};
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == LastCnt) begin
                        state_q <= StFinal;
                    end
                end
                StFinal: begin
                    // With den==0 the captured sign is just the sign of num
                    quo_q     <= dz_q ? (sign_q ? Q_MIN : Q_MAX) : sat_q;
                    ovf_q     <= dz_q ? 1'b0 : sat_ovf;
                    dz_flag_q <= dz_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quo_o         = quo_q;
    assign ovf_o         = ovf_q;
    assign div_by_zero_o = dz_flag_q;

endmodule

// File: tb/tb_fxp_div.sv
// Scoreboard bench for fxp_div: driver pushes model results, monitor pops on done.
module tb_fxp_div;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] num;
    logic [15:0] den;
    logic        busy;
    logic        done;
    logic [15:0] quo;
    logic        ovf;
    logic        dz;

    fxp_div dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .num_i         (num),
        .den_i         (den),
        .busy_o        (busy),
        .done_o        (done),
        .quo_o         (quo),
        .ovf_o         (ovf),
        .div_by_zero_o (dz)
    );

    typedef struct {
        logic [15:0] quo;
        logic        ovf;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact rational quotient with integer arithmetic, then clamp.
    function automatic exp_t model(input logic [15:0] n, input logic [15:0] d);
        exp_t   e;
        longint ni;
        longint di;
        longint an;
        longint ad;
        longint q;
        longint r;
        longint res;
        ni = longint'($signed(n));
        di = longint'($signed(d));
        e.acc = 0;
        e.lat = (d == 16'h0000) ? 1 : 25;
        if (di == 0) begin
            e.quo = (ni < 0) ? 16'h8000 : 16'h7FFF;
            e.ovf = 1'b0;
            e.dz  = 1'b1;
            return e;
        end
        e.dz = 1'b0;
        an   = ((ni < 0) ? -ni : ni) * 256;
        ad   = (di < 0) ? -di : di;
        q    = an / ad;
        r    = an % ad;
`ifdef FXP_DIV_ROUND_NEAREST_EN
        if (2 * r >= ad) q = q + 1;
`else
        if (r < 0) q = 0;  // r is never negative; keeps r referenced in both builds
`endif
        res = ((ni < 0) != (di < 0)) ? -q : q;
        if (res > 32767) begin
            e.quo = 16'h7FFF;
            e.ovf = 1'b1;
        end else if (res < -32768) begin
            e.quo = 16'h8000;
            e.ovf = 1'b1;
        end else begin
            e.quo = 16'(res);
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    // Waits for IDLE, drives operands with start high and returns just after the
    // accepting edge. start is left high; callers drop it or issue again.
    task automatic issue(input logic [15:0] n, input logic [15:0] d);
        int   w = 0;
        exp_t e;
        @(negedge clk);
        while (busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (busy) begin
            tests++;
            failed++;
            $display("FAIL issue_timeout: actual busy=1 required busy=0 within 100 cycles");
            return;
        end
        num   = n;
        den   = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        e     = model(n, d);
        e.acc = cyc;
        sb.push_back(e);
    endtask

    // Monitor: compare every done pulse against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (done && prev_done) begin
            tests++;
            failed++;
            $display("FAIL done_width: actual 2+ cycles required 1 cycle");
        end
        if (done) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_done: actual done=1 required no pending op, quo=%0h", quo);
            end else begin
                e = sb.pop_front();
                chk("quo", quo, e.quo);
                chk("ovf", ovf, e.ovf);
                chk("div_by_zero", dz, e.dz);
                chk("latency", cyc - e.acc, e.lat);
                chk("busy_at_done", busy, 0);
            end
        end
        prev_done = done;
    end

    initial begin
        int bc;
        int g;
        logic [15:0] rn;
        logic [15:0] rd;

        clk   = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        num   = '0;
        den   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_quo", quo, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_dz", dz, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;

        // 1.0 / 1.0 with busy-window length
        issue(16'h0100, 16'h0100);
        start = 1'b0;
        bc    = 0;
        @(negedge clk);
        while (busy && bc < 60) begin
            bc++;
            @(negedge clk);
        end
        chk("busy_cycles", bc, 25);

        // Back-to-back with start held across done
        issue(16'h1100, 16'h0200);
        issue(16'h0100, 16'h01FF);
        start = 1'b0;

        // Rounding-sensitive and exact negative cases
        issue(16'hFFFF, 16'h0200);
        start = 1'b0;
        issue(16'hFF00, 16'h0100);
        start = 1'b0;

        // Saturation boundaries
        issue(16'h7F00, 16'h0080);
        issue(16'h8000, 16'hFF00);
        issue(16'h8000, 16'h0100);
        start = 1'b0;

        // Divide by zero, both num signs, back-to-back
        issue(16'h0100, 16'h0000);
        issue(16'h8000, 16'h0000);
        start = 1'b0;

        // Reset mid-operation aborts without a done pulse
        issue(16'h0300, 16'h0100);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_quo", quo, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_dz", dz, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);

        // Restart after abort
        issue(16'h0300, 16'h0100);
        start = 1'b0;

        // start pulsed while busy is ignored
        issue(16'h0500, 16'h0300);
        start = 1'b0;
        repeat (5) @(negedge clk);
        num   = 16'h1234;
        den   = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Randomized operations, sometimes back-to-back
        for (int i = 0; i < 40; i++) begin
            rn = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rd = 16'($urandom);
                1: rd = ($urandom_range(0, 1) != 0) ? 16'(-$urandom_range(1, 255))
                                                     : 16'($urandom_range(1, 255));
                2: rd = 16'h0000;
                default: rd = 16'($urandom_range(0, 16'h0FFF));
            endcase
            issue(rn, rd);
            if ($urandom_range(0, 1) == 0) begin
                start = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        start = 1'b0;

        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain_timeout: actual %0d pending required 0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
